// File: rtl/sub_seq_64.sv
// Byte-serial 64-bit subtractor: one byte per cycle over 8 RUN cycles, with
// a registered result that is published atomically on the final byte.
module sub_seq_64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        bin,
  output logic        busy,
  output logic        done,
  output logic [63:0] diff,
  output logic        bout,
  output logic        zero
);

  localparam int unsigned W      = 64;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic              borrow_q, borrow_d;
  logic [W-1:0]      acc_q, acc_d;
  logic [W-1:0]      diff_d;
  logic              bout_d, zero_d, busy_d, done_d;

  logic [5:0]        idx_c;
  logic [BYTE_W-1:0] a_byte_c, b_byte_c;
  logic [BYTE_W:0]   sub_c;
  logic [W-1:0]      full_c;

  // Current byte slice; bit 8 of the 9-bit difference is the byte's borrow-out.
  always_comb begin
    idx_c    = {cnt_q, 3'b000};
    a_byte_c = a_q[idx_c +: BYTE_W];
    b_byte_c = b_q[idx_c +: BYTE_W];
    sub_c    = 9'(a_byte_c) - 9'(b_byte_c) - 9'(borrow_q);
    full_c   = {sub_c[BYTE_W-1:0], acc_q[55:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      acc_q    <= '0;
      diff     <= '0;
      bout     <= 1'b0;
      zero     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      acc_q    <= acc_d;
      diff     <= diff_d;
      bout     <= bout_d;
      zero     <= zero_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    acc_d    = acc_q;
    diff_d   = diff;
    bout_d   = bout;
    zero_d   = zero;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d[idx_c +: BYTE_W] = sub_c[BYTE_W-1:0];
        borrow_d = sub_c[BYTE_W];
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          diff_d  = full_c;
          bout_d  = sub_c[BYTE_W];
          zero_d  = (full_c == 64'd0);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_sub_seq_64.sv
// Self-checking bench for sub_seq_64: directed vector table, multi-cycle
// corner sequences and randomized operations against an arithmetic model.
module tb_sub_seq_64;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [63:0] diff;
  logic        bout;
  logic        zero;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] last_diff;
  logic        last_bout;
  logic        last_zero;
  time         t_done;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] diff;
    logic        bout;
    logic        zero;
  } vec_t;

  vec_t vecs[8];

  sub_seq_64 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation and follow it to its done pulse, checking latency,
  // busy length, result hold, and the final result against the reference.
  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_,
                        input logic tbin, input bit disturb, input string nm);
    logic [64:0] lhs, rhs;
    logic [63:0] e_diff;
    logic        e_bout, e_zero;
    int          edges, busy_cnt;
    bit          hold_ok;
    lhs    = {1'b0, ta};
    rhs    = {1'b0, tb_} + 65'(tbin);
    e_diff = ta - tb_ - 64'(tbin);
    e_bout = (lhs < rhs);
    e_zero = (e_diff == 64'd0);

    a = ta; b = tb_; bin = tbin; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0; busy_cnt = 0; hold_ok = 1'b1;
    while (done !== 1'b1 && edges < 20) begin
      if (busy === 1'b1) busy_cnt++;
      if (diff !== last_diff || bout !== last_bout || zero !== last_zero) hold_ok = 1'b0;
      if (disturb && edges == 2) begin
        start = 1'b1; a = ~ta; b = ta; bin = ~tbin;
      end
      if (disturb && edges == 3) start = 1'b0;
      if (edges == 1) begin a = ~ta; b = ~tb_; end
      tick();
      edges++;
    end
    start = 1'b0;
    chk({nm, " done"}, 64'(done), 64'd1);
    chk({nm, " latency"}, 64'(edges), 64'd8);
    chk({nm, " busy_cycles"}, 64'(busy_cnt), 64'd8);
    chk({nm, " busy_low"}, 64'(busy), 64'd0);
    chk({nm, " hold"}, 64'(hold_ok), 64'd1);
    chk({nm, " diff"}, diff, e_diff);
    chk({nm, " bout"}, 64'(bout), 64'(e_bout));
    chk({nm, " zero"}, 64'(zero), 64'(e_zero));
    last_diff = e_diff; last_bout = e_bout; last_zero = e_zero;
    t_done = $time;
  endtask

  initial begin
    time t1;
    int  k;

    vecs[0] = '{a: 64'd5, b: 64'd3, bin: 1'b0, diff: 64'd2, bout: 1'b0, zero: 1'b0};
    vecs[1] = '{a: 64'h0, b: 64'h1, bin: 1'b0, diff: 64'hFFFF_FFFF_FFFF_FFFF, bout: 1'b1, zero: 1'b0};
    vecs[2] = '{a: 64'h0000_0001_0000_0000, b: 64'h1, bin: 1'b0, diff: 64'h0000_0000_FFFF_FFFF, bout: 1'b0, zero: 1'b0};
    vecs[3] = '{a: 64'h1234_5678_9ABC_DEF0, b: 64'h1234_5678_9ABC_DEF0, bin: 1'b0, diff: 64'h0, bout: 1'b0, zero: 1'b1};
    vecs[4] = '{a: 64'h100, b: 64'h0, bin: 1'b1, diff: 64'hFF, bout: 1'b0, zero: 1'b0};
    vecs[5] = '{a: 64'h0, b: 64'h0, bin: 1'b1, diff: 64'hFFFF_FFFF_FFFF_FFFF, bout: 1'b1, zero: 1'b0};
    vecs[6] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, bin: 1'b1, diff: 64'hFFFF_FFFF_FFFF_FFFF, bout: 1'b1, zero: 1'b0};
    vecs[7] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'h0, bin: 1'b0, diff: 64'hFFFF_FFFF_FFFF_FFFF, bout: 1'b0, zero: 1'b0};

    // Reset with start held high: start must be ignored.
    rst = 1'b0; start = 1'b1; a = 64'd9; b = 64'd1; bin = 1'b0;
    tick(); tick();
    start = 1'b0;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset diff", diff, 64'd0);
    chk("reset bout", 64'(bout), 64'd0);
    chk("reset zero", 64'(zero), 64'd0);
    rst = 1'b1;
    tick();
    chk("idle busy", 64'(busy), 64'd0);
    last_diff = 64'd0; last_bout = 1'b0; last_zero = 1'b0;

    // Directed table: each vector with an idle cycle between operations.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl_diff", i), diff, vecs[i].diff);
      chk($sformatf("vec%0d tbl_bout", i), 64'(bout), 64'(vecs[i].bout));
      chk($sformatf("vec%0d tbl_zero", i), 64'(zero), 64'(vecs[i].zero));
      tick();
      chk($sformatf("vec%0d done_pulse", i), 64'(done), 64'd0);
    end

    // Start during RUN ignored, then back-to-back start in the DONE cycle.
    run_op(64'd5, 64'd3, 1'b0, 1'b1, "disturb");
    chk("disturb diff2", diff, 64'd2);
    t1 = t_done;
    run_op(64'h0, 64'h1, 1'b0, 1'b0, "b2b");
    chk("b2b spacing", 64'(t_done - t1), 64'd90);
    tick();

    // Reset at the 4th RUN edge aborts with no done pulse.
    a = 64'd5; b = 64'd3; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort diff", diff, 64'd0);
    chk("abort bout", 64'(bout), 64'd0);
    chk("abort zero", 64'(zero), 64'd0);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1 || busy === 1'b1) k++;
      tick();
    end
    chk("abort quiet", 64'(k), 64'd0);
    last_diff = 64'd0; last_bout = 1'b0; last_zero = 1'b0;
    run_op(64'd5, 64'd3, 1'b0, 1'b0, "post_abort");

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) rb = ra + 64'd1;
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
